// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding, opcode/alu_op constants and decoded control word
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, HALT = 3'd6
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FUNC_ILL = 6'h3F;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  typedef enum logic [2:0] {K_R, K_I, K_LW, K_SW, K_BR, K_HALT, K_ILL} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic       alu_src;
    logic       ext_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       branch_ne;
    logic       branch_e;
    logic       branch_tz;
    logic [2:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/func -> control word lookup
//   opcode, func : instruction fields
//   cw           : instruction class plus operand/writeback/branch controls
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output ctrl_t      cw
);
  always_comb begin
    cw = '0;
    cw.kind = K_ILL;
    case (opcode)
      OP_RTYPE: begin
        cw.kind = (func == FUNC_ILL) ? K_ILL : K_R;
        cw.alu_op = ALU_RTYPE;
        cw.reg_dst = 1'b1;
      end
      OP_ADDI: begin
        cw.kind = K_I;
        cw.alu_src = 1'b1;
        cw.ext_op = 1'b1;
        cw.alu_op = ALU_ADD;
      end
      OP_LW: begin
        cw.kind = K_LW;
        cw.alu_src = 1'b1;
        cw.ext_op = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.alu_op = ALU_ADD;
      end
      OP_SW: begin
        cw.kind = K_SW;
        cw.alu_src = 1'b1;
        cw.ext_op = 1'b1;
        cw.alu_op = ALU_ADD;
      end
      OP_BEQ: begin
        cw.kind = K_BR;
        cw.branch_e = 1'b1;
        cw.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        cw.kind = K_BR;
        cw.branch_ne = 1'b1;
        cw.alu_op = ALU_SUB;
      end
      OP_BGTZ: begin
        cw.kind = K_BR;
        cw.branch_tz = 1'b1;
        cw.alu_op = ALU_SUB;
      end
      OP_HALT: cw.kind = K_HALT;
      default: cw.kind = K_ILL;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath enables
//   clk, rst (sync, active-low), run, opcode, func : inputs
//   pc_wr, ir_wr, br_en, reg_wr, reg_dst, alu_src, ext_op, mem_to_reg,
//   mem_rd, mem_wr, branch_ne/e/tz, alu_op : per-cycle datapath controls
//   state, halted, illegal, instr_cnt : status
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  output logic        pc_wr,
  output logic        br_en,
  output logic        ir_wr,
  output logic        reg_wr,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        ext_op,
  output logic        mem_to_reg,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        branch_ne,
  output logic        branch_e,
  output logic        branch_tz,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instr_cnt
);
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);
  state_t     state_q, state_d;
  ctrl_t      cw_d, cw_q;
  logic [2:0] wcnt_q;
  logic       go_q;
  logic       retire;
  logic       in_op;
  ctrl_decode u_dec (.opcode(opcode), .func(func), .cw(cw_d));
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = run ? FETCH : IDLE;
      FETCH:   state_d = go_q ? DECODE : IDLE;
      DECODE:  state_d = (cw_d.kind == K_HALT || cw_d.kind == K_ILL) ? HALT : EXEC;
      EXEC:    state_d = (cw_q.kind == K_BR) ? FETCH : (cw_q.kind == K_LW || cw_q.kind == K_SW) ? MEM : WB;
      MEM:     state_d = (wcnt_q != 3'd0) ? MEM : (cw_q.kind == K_SW) ? FETCH : WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  assign retire = (state_q == WB)
               || (state_q == MEM && wcnt_q == 3'd0 && cw_q.kind == K_SW)
               || (state_q == EXEC && cw_q.kind == K_BR);
  // run is captured on the edge into FETCH; FETCH then either proceeds or drops to IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cw_q      <= '0;
      wcnt_q    <= '0;
      go_q      <= 1'b0;
      illegal   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state_q   <= state_d;
      cw_q      <= (state_q == DECODE) ? cw_d : cw_q;
      wcnt_q    <= (state_d == MEM) ? ((state_q == MEM) ? wcnt_q - 3'd1 : WAIT_INIT) : 3'd0;
      go_q      <= (state_d == FETCH) ? run : go_q;
      illegal   <= illegal | (state_q == DECODE && cw_d.kind == K_ILL);
      instr_cnt <= instr_cnt + {31'b0, retire};
    end
  end
  assign in_op      = state_q inside {EXEC, MEM, WB};
  assign pc_wr      = (state_q == FETCH) && go_q;
  assign ir_wr      = (state_q == FETCH) && go_q;
  assign br_en      = (state_q == EXEC) && (cw_q.kind == K_BR);
  assign branch_ne  = br_en & cw_q.branch_ne;
  assign branch_e   = br_en & cw_q.branch_e;
  assign branch_tz  = br_en & cw_q.branch_tz;
  assign alu_src    = in_op & cw_q.alu_src;
  assign ext_op     = in_op & cw_q.ext_op;
  assign alu_op     = in_op ? cw_q.alu_op : 3'b000;
  assign reg_wr     = (state_q == WB);
  assign reg_dst    = reg_wr & cw_q.reg_dst;
  assign mem_to_reg = reg_wr & cw_q.mem_to_reg;
  assign mem_rd     = (state_q == MEM) && (cw_q.kind == K_LW);
  // gated by rst so an interrupted store never strobes in the reset cycle
  assign mem_wr     = rst && (state_q == MEM) && (cw_q.kind == K_SW) && (wcnt_q == 3'd0);
  assign state      = state_q;
  assign halted     = (state_q == HALT);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vectors plus corner sequences for multicycle_ctrl (MEM_WAIT 0/2/3)
module tb_multicycle_ctrl;
  localparam logic [5:0] ADDI = 6'h08, RT = 6'h00, LW = 6'h23, SW = 6'h2B;
  localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, BGTZ = 6'h07, HLT = 6'h3F, BAD = 6'h11;
  localparam logic [15:0] B_PC = 16'h8000, B_IR = 16'h4000, B_BR = 16'h2000, B_RW = 16'h1000;
  localparam logic [15:0] B_RD = 16'h0800, B_AS = 16'h0400, B_EO = 16'h0200, B_MR = 16'h0100;
  localparam logic [15:0] B_MRD = 16'h0080, B_MWR = 16'h0040, B_BNE = 16'h0020, B_BE = 16'h0010, B_BTZ = 16'h0008;
  localparam logic [15:0] C_FETCH  = B_PC | B_IR;
  localparam logic [15:0] C_EX_I   = B_AS | B_EO;
  localparam logic [15:0] C_WB_I   = B_RW | B_AS | B_EO;
  localparam logic [15:0] C_EX_R   = 16'h0002;
  localparam logic [15:0] C_WB_R   = B_RW | B_RD | 16'h0002;
  localparam logic [15:0] C_MEM_SW = B_AS | B_EO | B_MWR;
  localparam logic [15:0] C_MEM_LW = B_AS | B_EO | B_MRD;
  localparam logic [15:0] C_WB_LW  = B_RW | B_MR | B_AS | B_EO;
  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic [2:0]  st;
    logic [15:0] ctl;
    logic [31:0] cnt;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0;
  logic [5:0] opcode = 6'h00, func = 6'h20;
  logic [2:0] pc_wr, br_en, ir_wr, reg_wr, reg_dst, alu_src, ext_op, mem_to_reg;
  logic [2:0] mem_rd, mem_wr, branch_ne, branch_e, branch_tz, halted, illegal;
  logic [2:0] alu_op [3];
  logic [2:0] state [3];
  logic [31:0] instr_cnt [3];
  int n_cmp = 0, n_bad = 0;
  vec_t tv [19];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gen
    multicycle_ctrl #(.MEM_WAIT(g == 0 ? 0 : g + 1)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func(func),
      .pc_wr(pc_wr[g]), .br_en(br_en[g]), .ir_wr(ir_wr[g]), .reg_wr(reg_wr[g]),
      .reg_dst(reg_dst[g]), .alu_src(alu_src[g]), .ext_op(ext_op[g]), .mem_to_reg(mem_to_reg[g]),
      .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]), .branch_ne(branch_ne[g]), .branch_e(branch_e[g]),
      .branch_tz(branch_tz[g]), .alu_op(alu_op[g]), .state(state[g]), .halted(halted[g]),
      .illegal(illegal[g]), .instr_cnt(instr_cnt[g])
    );
  end
  function automatic logic [15:0] ctl(int g);
    return {pc_wr[g], ir_wr[g], br_en[g], reg_wr[g], reg_dst[g], alu_src[g], ext_op[g], mem_to_reg[g],
            mem_rd[g], mem_wr[g], branch_ne[g], branch_e[g], branch_tz[g], alu_op[g]};
  endfunction
  function automatic vec_t v(logic r, logic [5:0] op, logic [2:0] st, logic [15:0] c, logic [31:0] n);
    vec_t x;
    x.run = r; x.op = op; x.st = st; x.ctl = c; x.cnt = n;
    return x;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    step();
    rst = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int nbr, nbe, nmem, nrd;
    logic [2:0] pat;
    step();
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst%0d state", g), 32'(state[g]), 32'd0);
      chk($sformatf("rst%0d ctl", g), 32'(ctl(g)), 32'd0);
      chk($sformatf("rst%0d cnt", g), instr_cnt[g], 32'd0);
      chk($sformatf("rst%0d halted", g), 32'(halted[g]), 32'd0);
      chk($sformatf("rst%0d illegal", g), 32'(illegal[g]), 32'd0);
    end
    tv[0]  = v(1'b1, ADDI, 3'd1, C_FETCH, 0);
    tv[1]  = v(1'b1, ADDI, 3'd2, 16'h0, 0);
    tv[2]  = v(1'b1, ADDI, 3'd3, C_EX_I, 0);
    tv[3]  = v(1'b1, ADDI, 3'd5, C_WB_I, 0);
    tv[4]  = v(1'b1, RT, 3'd1, C_FETCH, 1);
    tv[5]  = v(1'b1, RT, 3'd2, 16'h0, 1);
    tv[6]  = v(1'b1, RT, 3'd3, C_EX_R, 1);
    tv[7]  = v(1'b1, RT, 3'd5, C_WB_R, 1);
    tv[8]  = v(1'b1, SW, 3'd1, C_FETCH, 2);
    tv[9]  = v(1'b1, SW, 3'd2, 16'h0, 2);
    tv[10] = v(1'b1, SW, 3'd3, C_EX_I, 2);
    tv[11] = v(1'b1, SW, 3'd4, C_MEM_SW, 2);
    tv[12] = v(1'b1, LW, 3'd1, C_FETCH, 3);
    tv[13] = v(1'b1, LW, 3'd2, 16'h0, 3);
    tv[14] = v(1'b1, LW, 3'd3, C_EX_I, 3);
    tv[15] = v(1'b1, LW, 3'd4, C_MEM_LW, 3);
    tv[16] = v(1'b1, LW, 3'd5, C_WB_LW, 3);
    tv[17] = v(1'b0, LW, 3'd1, 16'h0, 4);
    tv[18] = v(1'b0, LW, 3'd0, 16'h0, 4);
    for (int i = 0; i < 19; i++) begin
      run = tv[i].run;
      opcode = tv[i].op;
      step();
      chk($sformatf("vec%0d state", i), 32'(state[0]), 32'(tv[i].st));
      chk($sformatf("vec%0d ctl", i), 32'(ctl(0)), 32'(tv[i].ctl));
      chk($sformatf("vec%0d cnt", i), instr_cnt[0], tv[i].cnt);
    end
    do_reset();
    run = 1'b1;
    opcode = BEQ;
    step();
    chk("beq fetch", 32'(state[1]), 32'd1);
    nbr = 0; nbe = 0; nmem = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nbr += int'(br_en[1]);
      nbe += int'(branch_e[1]);
      nmem += int'(mem_rd[1] | mem_wr[1]);
    end
    chk("beq next fetch", 32'(state[1]), 32'd1);
    chk("beq br_en cycles", 32'(nbr), 32'd1);
    chk("beq branch_e cycles", 32'(nbe), 32'd1);
    chk("beq mem strobes", 32'(nmem), 32'd0);
    chk("beq cnt", instr_cnt[1], 32'd1);
    opcode = BNE;
    repeat (2) step();
    chk("bne exec ctl", 32'(ctl(0)), 32'(B_BR | B_BNE | 16'h0001));
    step();
    chk("bne cnt", instr_cnt[0], 32'd2);
    opcode = BGTZ;
    repeat (2) step();
    chk("bgtz exec ctl", 32'(ctl(0)), 32'(B_BR | B_BTZ | 16'h0001));
    do_reset();
    run = 1'b1;
    opcode = SW;
    repeat (3) step();
    chk("sw exec", 32'(state[1]), 32'd3);
    pat = 3'b000; nmem = 0; nrd = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nmem += int'(state[1] == 3'd4);
      pat[i] = mem_wr[1];
      nrd += int'(mem_rd[1]);
    end
    chk("sw mem cycles", 32'(nmem), 32'd3);
    chk("sw mem_wr pattern", 32'(pat), 32'b100);
    chk("sw mem_rd", 32'(nrd), 32'd0);
    step();
    chk("sw next fetch", 32'(state[1]), 32'd1);
    chk("sw cnt", instr_cnt[1], 32'd1);
    do_reset();
    run = 1'b1;
    opcode = BEQ;
    repeat (4) step();
    chk("pre-lw cnt", instr_cnt[2], 32'd1);
    opcode = LW;
    repeat (4) step();
    chk("lw mem2 state", 32'(state[2]), 32'd4);
    chk("lw mem2 mem_rd", 32'(mem_rd[2]), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("lw rst state", 32'(state[2]), 32'd0);
    chk("lw rst ctl", 32'(ctl(2)), 32'd0);
    chk("lw rst cnt", instr_cnt[2], 32'd0);
    do_reset();
    run = 1'b1;
    opcode = SW;
    repeat (4) step();
    chk("sw0 mem state", 32'(state[0]), 32'd4);
    chk("sw0 mem_wr", 32'(mem_wr[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("sw0 mem_wr in rst", 32'(mem_wr[0]), 32'd0);
    step();
    rst = 1'b1;
    chk("sw0 after rst state", 32'(state[0]), 32'd0);
    chk("sw0 after rst mem_wr", 32'(mem_wr[0]), 32'd0);
    do_reset();
    run = 1'b1;
    opcode = BEQ;
    repeat (4) step();
    opcode = HLT;
    repeat (2) step();
    chk("halt state", 32'(state[0]), 32'd6);
    chk("halt halted", 32'(halted[0]), 32'd1);
    chk("halt illegal", 32'(illegal[0]), 32'd0);
    chk("halt cnt", instr_cnt[0], 32'd1);
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      step();
    end
    chk("halt absorb state", 32'(state[0]), 32'd6);
    chk("halt absorb ctl", 32'(ctl(0)), 32'd0);
    chk("halt absorb cnt", instr_cnt[0], 32'd1);
    do_reset();
    chk("halt rst state", 32'(state[0]), 32'd0);
    chk("halt rst halted", 32'(halted[0]), 32'd0);
    run = 1'b1;
    opcode = BAD;
    repeat (3) step();
    chk("bad state", 32'(state[0]), 32'd6);
    chk("bad illegal", 32'(illegal[0]), 32'd1);
    chk("bad cnt", instr_cnt[0], 32'd0);
    do_reset();
    chk("bad rst illegal", 32'(illegal[0]), 32'd0);
    run = 1'b1;
    opcode = RT;
    func = 6'h3F;
    repeat (3) step();
    chk("rfunc state", 32'(state[0]), 32'd6);
    chk("rfunc illegal", 32'(illegal[0]), 32'd1);
    func = 6'h20;
    do_reset();
    run = 1'b1;
    opcode = ADDI;
    repeat (2) step();
    force gen[0].dut.instr_cnt = 32'hFFFF_FFFF;
    #1;
    release gen[0].dut.instr_cnt;
    step();
    chk("wrap exec cnt", instr_cnt[0], 32'hFFFF_FFFF);
    step();
    chk("wrap wb state", 32'(state[0]), 32'd5);
    run = 1'b0;
    step();
    chk("wrap cnt", instr_cnt[0], 32'd0);
    chk("wrap fetch pc_wr", 32'(pc_wr[0]), 32'd0);
    step();
    chk("wrap idle", 32'(state[0]), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
